keypad_read_sequencer: RTL and testbench
========================================

// Module: keypad_read_sequencer
// PURPOSE
//  Owns the KeyReady/KeyRead handshake of the keypad interpreter. Captures each decoded key
//  (4-bit DataOut) into a small FIFO, acknowledges the interpreter with a bounded KeyRead
//  pulse and presents buffered keys downstream on a valid/ready interface. Sits between the
//  interpreter and any key consumer (display, code-entry logic); decouples consumer latency
//  from the scanner's 8 ms KeyRead limit.
// PARAMETERS
//  DEPTH    8       FIFO entries; power of 2, >= 2
//  ACK_MAX  100000  max clocks KeyRead may stay high (set below 8 ms at system clock)
// PORTS
//  Clock       in   1  system clock; all state updates on rising edge
//  ResetButton in   1  reset, asynchronous, active-low
//  Clear       in   1  sync flush: empties FIFO, clears AckTimeout, FSM -> IDLE
//  KeyReady    in   1  interpreter: key available, held until KeyRead seen
//  DataIn      in   4  interpreter DataOut, valid while KeyReady=1
//  KeyRead     out  1  ack to interpreter (registered)
//  KeyValid    out  1  FIFO head valid (= !empty)
//  KeyData     out  4  FIFO head value; holds last-read value when empty
//  KeyAccept   in   1  consumer pops head when KeyValid && KeyAccept
//  Count       out  log2(DEPTH)+1  FIFO occupancy
//  AckTimeout  out  1  sticky: KeyReady stayed high ACK_MAX clocks into ACK
// BEHAVIOUR
//  Reset (async assert): KeyRead=0, KeyValid=0, KeyData=0, Count=0, AckTimeout=0,
//   FSM=IDLE, FIFO pointers=0. Release is synchronised by the two-flop chain below.
//  FSM (registered, 3 states):
//   IDLE    KeyReady=1 && !full: push DataIn, ->ACK; KeyRead=1 from next cycle.
//           KeyReady=1 && full: no push, no ack; the scanner stalls (back-pressure).
//   ACK     KeyRead=1; ack counter increments every cycle.
//           KeyReady=0 observed: ->IDLE, KeyRead=0 next cycle.
//           counter==ACK_MAX-1 while KeyReady=1: set AckTimeout, ->RELEASE, KeyRead=0.
//   RELEASE KeyRead=0; wait for KeyReady=0, then ->IDLE. No push occurs here, so one
//           key is never captured twice.
//  Latency: KeyReady rise at edge n -> push at edge n -> KeyValid=1 after edge n
//   (first-word fall-through) -> KeyRead=1 after edge n+1.
//  FIFO: circular, log2(DEPTH)+1-bit pointers, and pointer MSB distinguishes full from empty.
//   Push and pop in the same cycle: both occur, Count unchanged. When full, a same-cycle pop
//   does NOT enable that cycle's push; full is the registered flag.
//   Pop when empty is ignored. Pointers wrap modulo DEPTH.
//  Clear: takes priority over push and pop in the same cycle. KeyRead drops next cycle.
//   If KeyReady is still high, the FSM goes ->RELEASE rather than IDLE, so no stale
//   re-capture occurs.
//  Reset mid-ACK: KeyRead drops immediately (async). The interpreter has its own reset,
//   so the same key may reappear and is captured again.
//  KeyReady is treated as synchronous to Clock; the interpreter drives it from the same clock.
// STRUCTURE
//  Shared package keypad_pkg: KEY_W=4, FSM state localparams (IDLE/ACK/RELEASE),
//   and the default ACK_MAX.
//  Sub-module key_fifo (DEPTH, KEY_W): push/pop/clear, dout, count, full, empty.
//  Top level: FSM, ack counter, reset synchroniser (2 flops, async assert, sync release).
// TESTING
//  1 Single key: DataIn=4'h7, KeyReady pulse released after 3 clocks of KeyRead -> one push,
//    KeyData=7, Count=1, KeyRead high exactly 3 cycles (+1 registered tail).
//  2 Fill: 9 keys with KeyAccept=0, DEPTH=8 -> Count=8. The 9th keeps KeyReady high with
//    KeyRead=0. One pop -> 9th captured, Count=8.
//  3 Timeout: ACK_MAX=16, KeyReady held high -> KeyRead high 16 cycles, AckTimeout=1,
//    no second push. KeyReady low -> IDLE; the next key is captured normally.
//  4 Simultaneous: Count=3, push and pop on the same edge -> Count=3, order preserved
//    (FIFO check over 20 random keys, including wrap).
//  5 Clear during ACK with KeyReady=1 -> Count=0, AckTimeout=0, KeyRead=0 next cycle,
//    no push until KeyReady has fallen and risen again.
//  6 Async reset asserted mid-ACK, between edges -> KeyRead=0 without a clock edge.
//    All outputs at reset values. Sequence resumes cleanly after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad read sequencer and its key FIFO.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ACK_MAX_DEFAULT = 100000;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StRelease
  } seqState_e;

endpackage

// File: rtl/key_fifo.sv
// Circular key FIFO with first-word fall-through; the head output holds the last popped
// value while empty.
module key_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned KEY_W = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW:0]      wrPtrQ, rdPtrQ;
  logic [KEY_W-1:0] lastQ;
  logic             doPush, doPop;

  assign empty  = (wrPtrQ == rdPtrQ);
  assign full   = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  // full/empty come from registered pointers, so a same-cycle pop never frees room
  assign doPush = push && !full && !clear;
  assign doPop  = pop && !empty && !clear;
  assign count  = wrPtrQ - rdPtrQ;
  assign dout   = empty ? lastQ : mem[rdPtrQ[AW-1:0]];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      lastQ  <= '0;
    end else if (clear) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
        lastQ  <= mem[rdPtrQ[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keypad_read_sequencer.sv
// KeyReady/KeyRead handshake owner: captures interpreter keys into a FIFO and presents them
// downstream on a valid/ready interface, with a bounded acknowledge pulse.
module keypad_read_sequencer
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ACK_MAX = ACK_MAX_DEFAULT,
  localparam int unsigned CW = $clog2(DEPTH) + 1,
  localparam int unsigned AckW = $clog2(ACK_MAX + 1)
) (
  input  logic             Clock,
  input  logic             ResetButton,
  input  logic             Clear,
  input  logic             KeyReady,
  input  logic [KEY_W-1:0] DataIn,
  output logic             KeyRead,
  output logic             KeyValid,
  output logic [KEY_W-1:0] KeyData,
  input  logic             KeyAccept,
  output logic [CW-1:0]    Count,
  output logic             AckTimeout
);

  logic [1:0]      rstSyncQ;
  logic            rstN;
  seqState_e       stateQ, stateD;
  logic [AckW-1:0] ackCntQ, ackCntD;
  logic            timeoutD, keyReadD, keyReadQ, timeoutQ;
  logic            push, full, empty;

  // Asynchronous assert, release after two clock edges
  always_ff @(posedge Clock or negedge ResetButton) begin
    if (!ResetButton) rstSyncQ <= 2'b00;
    else              rstSyncQ <= {rstSyncQ[0], 1'b1};
  end
  assign rstN = rstSyncQ[1];

  key_fifo #(
    .DEPTH(DEPTH),
    .KEY_W(KEY_W)
  ) uFifo (
    .clk  (Clock),
    .rstN (rstN),
    .push (push),
    .pop  (KeyAccept),
    .clear(Clear),
    .din  (DataIn),
    .dout (KeyData),
    .count(Count),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    stateD   = stateQ;
    ackCntD  = ackCntQ;
    timeoutD = timeoutQ;
    push     = 1'b0;
    if (Clear) begin
      // A key still asserted at flush time must not be re-captured
      stateD   = KeyReady ? StRelease : StIdle;
      ackCntD  = '0;
      timeoutD = 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (KeyReady && !full) begin
            push    = 1'b1;
            stateD  = StAck;
            ackCntD = '0;
          end
        end
        StAck: begin
          if (!KeyReady) begin
            stateD = StIdle;
          end else if (ackCntQ == AckW'(ACK_MAX - 1)) begin
            timeoutD = 1'b1;
            stateD   = StRelease;
          end else begin
            ackCntD = ackCntQ + 1'b1;
          end
        end
        StRelease: begin
          if (!KeyReady) stateD = StIdle;
        end
        default: stateD = StIdle;
      endcase
    end
    keyReadD = (stateQ == StAck) && !Clear;
  end

  always_ff @(posedge Clock or negedge rstN) begin
    if (!rstN) begin
      stateQ   <= StIdle;
      ackCntQ  <= '0;
      timeoutQ <= 1'b0;
      keyReadQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      ackCntQ  <= ackCntD;
      timeoutQ <= timeoutD;
      keyReadQ <= keyReadD;
    end
  end

  assign KeyRead    = keyReadQ;
  assign AckTimeout = timeoutQ;
  assign KeyValid   = !empty;

endmodule

// File: tb/tb_keypad_read_sequencer.sv
// Directed bench for keypad_read_sequencer (DEPTH=8, ACK_MAX=16).
module tb_keypad_read_sequencer;

  logic       Clock = 1'b0;
  logic       ResetButton, Clear, KeyReady, KeyAccept;
  logic [3:0] DataIn;
  logic       KeyRead, KeyValid, AckTimeout;
  logic [3:0] KeyData;
  logic [3:0] Count;

  int passCnt = 0;
  int totalCnt = 0;
  logic [3:0] q[$];

  keypad_read_sequencer #(
    .DEPTH(8),
    .ACK_MAX(16)
  ) dut (
    .Clock      (Clock),
    .ResetButton(ResetButton),
    .Clear      (Clear),
    .KeyReady   (KeyReady),
    .DataIn     (DataIn),
    .KeyRead    (KeyRead),
    .KeyValid   (KeyValid),
    .KeyData    (KeyData),
    .KeyAccept  (KeyAccept),
    .Count      (Count),
    .AckTimeout (AckTimeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Full handshake for one key; leaves the FSM idle with KeyRead low
  task automatic sendKey(input logic [3:0] k);
    int n;
    n = 0;
    DataIn   = k;
    KeyReady = 1'b1;
    while (!KeyRead && n < 40) begin
      tick();
      n++;
    end
    check("ackWait", n < 40, 1);
    KeyReady = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int hiCnt;
    logic [3:0] k;
    ResetButton = 1'b0;
    Clear = 1'b0;
    KeyReady = 1'b0;
    KeyAccept = 1'b0;
    DataIn = '0;
    tick();
    tick();
    check("rstKeyRead", KeyRead, 0);
    check("rstKeyValid", KeyValid, 0);
    check("rstKeyData", KeyData, 0);
    check("rstCount", Count, 0);
    check("rstTimeout", AckTimeout, 0);
    ResetButton = 1'b1;
    tick();
    tick();
    tick();

    // 1: single key, KeyRead high 3 cycles then a 1-cycle tail
    DataIn = 4'h7;
    KeyReady = 1'b1;
    tick();
    check("t1Valid", KeyValid, 1);
    check("t1Data", KeyData, 4'h7);
    check("t1Count", Count, 1);
    check("t1ReadLate", KeyRead, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1ReadHi", KeyRead, 1);
    end
    KeyReady = 1'b0;
    tick();
    check("t1Tail", KeyRead, 1);
    tick();
    check("t1ReadLo", KeyRead, 0);
    check("t1Count1", Count, 1);
    KeyAccept = 1'b1;
    tick();
    KeyAccept = 1'b0;
    check("t1PopCount", Count, 0);
    check("t1PopValid", KeyValid, 0);
    check("t1HoldData", KeyData, 4'h7);

    // 2: fill to DEPTH, back-pressure, one pop admits the 9th key
    for (int i = 1; i <= 8; i++) sendKey(4'(i));
    check("t2Full", Count, 8);
    check("t2Head", KeyData, 1);
    DataIn = 4'h9;
    KeyReady = 1'b1;
    tick();
    tick();
    tick();
    check("t2NoAck", KeyRead, 0);
    check("t2Stall", Count, 8);
    KeyAccept = 1'b1;
    tick();
    KeyAccept = 1'b0;
    check("t2Pop", Count, 7);
    tick();
    check("t2Push9", Count, 8);
    check("t2Read0", KeyRead, 0);
    tick();
    check("t2Read1", KeyRead, 1);
    KeyReady = 1'b0;
    tick();
    tick();
    KeyAccept = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check("t2Order", KeyData, i);
      tick();
    end
    KeyAccept = 1'b0;
    check("t2Empty", Count, 0);

    // 3: ack timeout with KeyReady held
    DataIn = 4'hA;
    KeyReady = 1'b1;
    tick();
    hiCnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (KeyRead) hiCnt++;
    end
    check("t3HighCycles", hiCnt, 16);
    check("t3Timeout", AckTimeout, 1);
    check("t3NoRepush", Count, 1);
    KeyReady = 1'b0;
    tick();
    check("t3Sticky", AckTimeout, 1);
    sendKey(4'hB);
    check("t3Next", Count, 2);
    KeyAccept = 1'b1;
    check("t3HeadA", KeyData, 4'hA);
    tick();
    check("t3HeadB", KeyData, 4'hB);
    tick();
    KeyAccept = 1'b0;
    check("t3Drained", Count, 0);

    // 4: simultaneous push/pop at Count=3, ordering across pointer wrap
    for (int i = 1; i <= 3; i++) begin
      sendKey(4'(i));
      q.push_back(4'(i));
    end
    for (int i = 0; i < 20; i++) begin
      k = 4'($urandom_range(0, 15));
      check("t4Head", KeyData, q[0]);
      DataIn = k;
      KeyReady = 1'b1;
      KeyAccept = 1'b1;
      tick();
      KeyAccept = 1'b0;
      void'(q.pop_front());
      q.push_back(k);
      check("t4Count", Count, 3);
      tick();
      KeyReady = 1'b0;
      tick();
      tick();
    end
    KeyAccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4Drain", KeyData, q[i]);
      tick();
    end
    KeyAccept = 1'b0;
    check("t4Empty", Count, 0);

    // 5: Clear during ACK with KeyReady still high
    sendKey(4'h5);
    DataIn = 4'h6;
    KeyReady = 1'b1;
    tick();
    check("t5Count2", Count, 2);
    tick();
    check("t5InAck", KeyRead, 1);
    check("t5TimeoutBefore", AckTimeout, 1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("t5ClrCount", Count, 0);
    check("t5ClrValid", KeyValid, 0);
    check("t5ClrRead", KeyRead, 0);
    check("t5ClrTimeout", AckTimeout, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t5NoRecapture", Count, 0);
    check("t5NoAck", KeyRead, 0);
    KeyReady = 1'b0;
    tick();
    DataIn = 4'h8;
    KeyReady = 1'b1;
    tick();
    check("t5NewKey", Count, 1);
    check("t5NewData", KeyData, 4'h8);
    tick();
    KeyReady = 1'b0;
    tick();
    tick();

    // 6: async reset between edges mid-ACK
    DataIn = 4'h3;
    KeyReady = 1'b1;
    tick();
    tick();
    check("t6InAck", KeyRead, 1);
    #2;
    ResetButton = 1'b0;
    #1;
    check("t6AsyncRead", KeyRead, 0);
    check("t6AsyncValid", KeyValid, 0);
    check("t6AsyncCount", Count, 0);
    check("t6AsyncData", KeyData, 0);
    check("t6AsyncTimeout", AckTimeout, 0);
    KeyReady = 1'b0;
    tick();
    tick();
    ResetButton = 1'b1;
    tick();
    tick();
    tick();
    sendKey(4'h3);
    check("t6Resume", Count, 1);
    check("t6ResumeData", KeyData, 4'h3);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
